// File: rtl/mem_io_bridge_pkg.sv
// Shared command/state types and IO address map for the memory/IO bridge,
// the CPU control FSM and the benches.
package mem_io_bridge_pkg;

   localparam int MEM_AW = 9;
   localparam int MEM_DW = 16;

   localparam logic [MEM_AW-1:0] LED_ADDR = 9'h100;
   localparam logic [MEM_AW-1:0] SW_ADDR  = 9'h140;

   typedef enum logic [1:0] {
      MNONE    = 2'b00,
      MREAD    = 2'b01,
      MWRITE   = 2'b10,
      MILLEGAL = 2'b11
   } mem_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_RAM,
      RESP
   } bridge_state_t;

endpackage

// File: rtl/mem_io_bridge_if.sv
// Core-side access bus: command/address/write data from the core,
// read data and completion pulse back from the bridge.
interface mem_io_bridge_if
   import mem_io_bridge_pkg::*;
#(
   parameter int AW = MEM_AW,
   parameter int DW = MEM_DW
);

   mem_cmd_t        mem_cmd;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   wdata;
   logic [DW-1:0]   rdata;
   logic            mem_ready;

   modport master (
      output mem_cmd, mem_addr, wdata,
      input  rdata, mem_ready
   );

   modport slave (
      input  mem_cmd, mem_addr, wdata,
      output rdata, mem_ready
   );

endinterface

// File: rtl/sync_nff.sv
// N-deep flop chain bringing an asynchronous bus into the clk domain.
module sync_nff #(
   parameter int N     = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [N-1:0][WIDTH-1:0] chain_q;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[N-2:0], d_i};
      end
   end

   assign q_o = chain_q[N-1];

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO stage behind the CPU core: decodes core accesses to RAM, LED
// register and switch port, and signals completion with a one-cycle mem_ready.
module mem_io_bridge #(
   parameter int                RAM_AW   = 8,
   parameter int                DW       = 16,
   parameter logic [RAM_AW:0]   LED_ADDR = mem_io_bridge_pkg::LED_ADDR,
   parameter logic [RAM_AW:0]   SW_ADDR  = mem_io_bridge_pkg::SW_ADDR,
   parameter int                SYNC_N   = 2
) (
   input  logic              clk,
   input  logic              reset,
   mem_io_bridge_if.slave    bus,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [DW-1:0]     ram_wdata,
   output logic              ram_we,
   input  logic [DW-1:0]     ram_rdata,
   input  logic [7:0]        sw_in,
   output logic [7:0]        led_out,
   output logic              err
);

   import mem_io_bridge_pkg::*;

   bridge_state_t state_q, state_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [7:0]    led_q, led_d;
   logic          err_q, err_d;
   logic [7:0]    sw_sync;
   logic          is_ram, is_led, is_sw;

   sync_nff #(
      .N     (SYNC_N),
      .WIDTH (8)
   ) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (sw_in),
      .q_o   (sw_sync)
   );

   assign is_ram = ~bus.mem_addr[RAM_AW];
   assign is_led = (bus.mem_addr == LED_ADDR);
   assign is_sw  = (bus.mem_addr == SW_ADDR);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      led_d   = led_q;
      err_d   = err_q;
      ram_we  = 1'b0;

      unique case (state_q)
         IDLE: begin
            unique case (bus.mem_cmd)
               MREAD: begin
                  if (is_ram) begin
                     state_d = RD_RAM;
                  end else begin
                     state_d = RESP;
                     if (is_sw) begin
                        rdata_d = {{(DW-8){1'b0}}, sw_sync};
                     end else if (is_led) begin
                        rdata_d = {{(DW-8){1'b0}}, led_q};
                     end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                     end
                  end
               end
               MWRITE: begin
                  state_d = RESP;
                  // The strobe is gated by reset so a write never lands in a reset cycle.
                  if (is_ram) begin
                     ram_we = reset;
                  end else if (is_led) begin
                     led_d = bus.wdata[7:0];
                  end else begin
                     err_d = 1'b1;
                  end
               end
               MILLEGAL: err_d = 1'b1;
               default:  state_d = IDLE;
            endcase
         end
         RD_RAM: begin
            state_d = RESP;
            rdata_d = ram_rdata;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         rdata_q <= '0;
         led_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         led_q   <= led_d;
         err_q   <= err_d;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.mem_ready = (state_q == RESP);
   assign ram_addr      = bus.mem_addr[RAM_AW-1:0];
   assign ram_wdata     = bus.wdata;
   assign led_out       = led_q;
   assign err           = err_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: transaction-level model checked every
// cycle, plus literal expectations on key results.
module tb_mem_io_bridge;
   import mem_io_bridge_pkg::*;

   logic        clk;
   logic        reset;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we;
   logic [15:0] ram_rdata;
   logic [7:0]  sw_in;
   logic [7:0]  led_out;
   logic        err;

   mem_io_bridge_if bus ();

   mem_io_bridge dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .sw_in     (sw_in),
      .led_out   (led_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment RAM: synchronous, read data one cycle after the address.
   logic [15:0] tb_ram [256];
   always @(posedge clk) begin
      if (ram_we) tb_ram[ram_addr] <= ram_wdata;
      ram_rdata <= tb_ram[ram_addr];
   end

   // Model state: what the outputs must show in the current cycle.
   logic [15:0] model_mem [256];
   logic [15:0] exp_rdata;
   logic [7:0]  exp_led;
   logic        exp_err;
   logic        exp_ready;
   logic        exp_we;
   logic [7:0]  sw_model;
   logic        chk_en;

   int n_cmp;
   int n_bad;
   int ready_cnt;
   int we_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("rdata",     bus.rdata,     exp_rdata);
         check("mem_ready", bus.mem_ready, exp_ready);
         check("ram_we",    ram_we,        exp_we);
         check("led_out",   led_out,       exp_led);
         check("err",       err,           exp_err);
         check("ram_addr",  ram_addr,      bus.mem_addr[7:0]);
         check("ram_wdata", ram_wdata,     bus.wdata);
         if (bus.mem_ready === 1'b1) ready_cnt++;
         if (ram_we === 1'b1) we_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete access following the core handshake; returns in the cycle
   // after mem_ready with the bus idle, so calls can run back to back.
   task automatic issue(input mem_cmd_t cmd, input logic [8:0] addr, input logic [15:0] wd);
      int lat;
      bus.mem_cmd  = cmd;
      bus.mem_addr = addr;
      bus.wdata    = wd;
      exp_ready    = 1'b0;
      exp_we       = (cmd == MWRITE) && (addr[8] == 1'b0);
      if (cmd == MILLEGAL || cmd == MNONE) begin
         step();
         bus.mem_cmd = MNONE;
         exp_we      = 1'b0;
         if (cmd == MILLEGAL) exp_err = 1'b1;
         return;
      end
      lat = (cmd == MREAD && addr[8] == 1'b0) ? 3 : 2;
      for (int c = 1; c < lat; c++) begin
         step();
         exp_we = 1'b0;
      end
      exp_ready = 1'b1;
      if (cmd == MREAD) begin
         if (addr[8] == 1'b0)        exp_rdata = model_mem[addr[7:0]];
         else if (addr == LED_ADDR)  exp_rdata = {8'h00, exp_led};
         else if (addr == SW_ADDR)   exp_rdata = {8'h00, sw_model};
         else begin
            exp_rdata = 16'h0000;
            exp_err   = 1'b1;
         end
      end else begin
         if (addr[8] == 1'b0)        model_mem[addr[7:0]] = wd;
         else if (addr == LED_ADDR)  exp_led = wd[7:0];
         else                        exp_err = 1'b1;
      end
      step();
      bus.mem_cmd = MNONE;
      exp_ready   = 1'b0;
   endtask

   logic [8:0]  vec_addr [3];
   logic [15:0] vec_data [3];
   int          rc_before;

   initial begin
      n_cmp = 0; n_bad = 0; ready_cnt = 0; we_cnt = 0;
      chk_en = 1'b0;
      for (int i = 0; i < 256; i++) begin
         tb_ram[i]    = 16'h0000;
         model_mem[i] = 16'h0000;
      end
      vec_addr[0] = 9'h000; vec_data[0] = 16'h1111;
      vec_addr[1] = 9'h0FF; vec_data[1] = 16'hFFFF;
      vec_addr[2] = 9'h080; vec_data[2] = 16'h8001;

      // 1: reset with writes pending; nothing may take effect.
      reset        = 1'b0;
      sw_in        = 8'h00;
      sw_model     = 8'h00;
      bus.mem_cmd  = MWRITE;
      bus.mem_addr = LED_ADDR;
      bus.wdata    = 16'h00FF;
      step();
      exp_rdata = 16'h0000; exp_led = 8'h00; exp_err = 1'b0;
      exp_ready = 1'b0;     exp_we  = 1'b0;
      chk_en    = 1'b1;
      bus.mem_addr = 9'h007;
      bus.wdata    = 16'hDEAD;
      step();
      reset       = 1'b1;
      bus.mem_cmd = MNONE;
      step();
      check("lit_reset_led", led_out, 8'h00);
      check("lit_reset_err", err, 1'b0);

      // 2: RAM write then read back, plus a write suppressed by reset.
      issue(MWRITE, 9'h005, 16'hABCD);
      check("lit_one_we_pulse", we_cnt, 1);
      issue(MREAD, 9'h005, 16'h0000);
      check("lit_rd_abcd", bus.rdata, 16'hABCD);
      issue(MREAD, 9'h007, 16'h0000);
      check("lit_rd_no_reset_write", bus.rdata, 16'h0000);
      for (int i = 0; i < 3; i++) issue(MWRITE, vec_addr[i], vec_data[i]);
      for (int i = 0; i < 3; i++) issue(MREAD, vec_addr[i], 16'h0000);
      check("lit_rd_8001", bus.rdata, 16'h8001);
      check("lit_we_count", we_cnt, 4);

      // 3: switch read after synchroniser settles; LED write and read back.
      sw_in = 8'h5A;
      step(); step(); step();
      sw_model = 8'h5A;
      issue(MREAD, SW_ADDR, 16'h0000);
      check("lit_sw_read", bus.rdata, 16'h005A);
      issue(MWRITE, LED_ADDR, 16'h1234);
      check("lit_led_34", led_out, 8'h34);
      issue(MREAD, LED_ADDR, 16'h0000);
      check("lit_led_read", bus.rdata, 16'h0034);

      // 4: illegal command, then unmapped read.
      rc_before = ready_cnt;
      issue(MILLEGAL, 9'h005, 16'h0000);
      step(); step();
      check("lit_illegal_err", err, 1'b1);
      check("lit_illegal_no_ready", ready_cnt, rc_before);
      issue(MREAD, 9'h1FF, 16'h0000);
      check("lit_unmapped_rdata", bus.rdata, 16'h0000);
      check("lit_err_sticky", err, 1'b1);

      // 5: bus changes while the RAM read is in flight are ignored.
      bus.mem_cmd  = MREAD;
      bus.mem_addr = 9'h005;
      bus.wdata    = 16'h0000;
      exp_we       = 1'b0;
      step();
      bus.mem_cmd  = MWRITE;
      bus.mem_addr = 9'h010;
      bus.wdata    = 16'h7777;
      step();
      exp_ready = 1'b1;
      exp_rdata = model_mem[5];
      step();
      bus.mem_cmd = MNONE;
      exp_ready   = 1'b0;
      check("lit_busy_rdata", bus.rdata, 16'hABCD);
      issue(MREAD, 9'h010, 16'h0000);
      check("lit_busy_no_write", bus.rdata, 16'h0000);
      issue(MREAD, 9'h005, 16'h0000);

      // 6: reset while the read is in RD_RAM aborts it.
      rc_before    = ready_cnt;
      bus.mem_cmd  = MREAD;
      bus.mem_addr = 9'h0FF;
      step();
      reset = 1'b0;
      step();
      reset       = 1'b1;
      bus.mem_cmd = MNONE;
      exp_rdata = 16'h0000; exp_led = 8'h00; exp_err = 1'b0;
      sw_model  = 8'h00;
      step(); step(); step();
      sw_model = 8'h5A;
      check("lit_abort_no_ready", ready_cnt, rc_before);
      check("lit_abort_rdata", bus.rdata, 16'h0000);
      check("lit_abort_err", err, 1'b0);
      issue(MREAD, 9'h0FF, 16'h0000);
      issue(MREAD, 9'h005, 16'h0000);
      issue(MREAD, SW_ADDR, 16'h0000);
      check("lit_resume_sw", bus.rdata, 16'h005A);
      issue(MWRITE, SW_ADDR, 16'h00AA);
      check("lit_write_sw_err", err, 1'b1);
      step(); step();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
